serial_operand_tx: RTL and testbench

- Upstream feeder for the serial multiplier. Accepts one parallel operand set (length, multiplier, multiplicand) per valid/ready handshake.
- Emits the set as a single framed bit-serial stream on ser_ctrl/ser_data: start cycle, length field, multiplier field, multiplicand field, optional parity, inter-frame gap.
- Sits between the register/bus front-end and the serial multiply stage. One frame in flight at a time.

---
 rtl/serial_mult_pkg.sv | 30 +++
 rtl/piso_shreg.sv | 33 +++
 rtl/serial_operand_tx.sv | 216 +++++++++++++++++++++
 tb/tb_serial_operand_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
// Shared definitions for the serial multiplier datapath.
//   - state_t : transmitter FSM states
//   - field_t : order of fields within a serial frame, shared with the
//               downstream multiply stage
//   - DEF_*   : default operand width, length-field width and gap length
package serial_mult_pkg;

    localparam int DEF_OPW  = 32;
    localparam int DEF_LENW = 8;
    localparam int DEF_GAP  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LEN,
        ST_MPL,
        ST_MCD,
        ST_PAR,
        ST_GAP
    } state_t;

    // Field order on the wire after the start cycle.
    typedef enum logic [1:0] {
        FLD_LEN = 2'd0,
        FLD_MPL = 2'd1,
        FLD_MCD = 2'd2,
        FLD_PAR = 2'd3
    } field_t;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register, shifting right with the LSB as
// the serial output.
//   clk, rst : clock, asynchronous active-low reset
//   load     : capture din (has priority over shift)
//   shift    : shift right by one, zero fill at the MSB
//   din      : parallel load value
//   lsb      : current serial bit (register bit 0)
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         lsb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {1'b0, sr[W-1:1]};
        end
    end

    assign lsb = sr[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Serial operand transmitter: accepts one (length, multiplier,
// multiplicand) set per valid/ready handshake and sends it as a framed
// bit-serial stream: start, length, multiplier[L-1:0], multiplicand,
// optional parity, inter-frame gap.
//
// Optional feature macro: SERIAL_PARITY_EN (adds a 1-cycle even-parity
// bit after the multiplicand; frame_done moves to that cycle).
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   in_valid    : operand set valid
//   in_ready    : can accept this cycle (high only in IDLE)
//   in_length   : multiplier bit count, clamped to OPW
//   in_mplier   : multiplier
//   in_mcand    : multiplicand
//   ser_ctrl    : frame start strobe
//   ser_data    : serial data bit
//   busy        : frame (including gap) in progress
//   frame_done  : pulse on the last field bit
//   len_err     : sticky, set when a length was clamped
//
// state    | meaning
// ST_IDLE  | waiting for an operand set
// ST_START | start cycle, ser_ctrl high
// ST_LEN   | length field, LENW bits LSB first
// ST_MPL   | multiplier, L bits LSB first (skipped when L == 0)
// ST_MCD   | multiplicand, OPW bits LSB first
// ST_PAR   | even parity over all field bits (SERIAL_PARITY_EN only)
// ST_GAP   | idle gap, GAP cycles
module serial_operand_tx
    import serial_mult_pkg::*;
#(
    parameter int OPW  = DEF_OPW,
    parameter int LENW = DEF_LENW,
    parameter int GAP  = DEF_GAP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LENW-1:0] in_length,
    input  logic [OPW-1:0]  in_mplier,
    input  logic [OPW-1:0]  in_mcand,
    output logic            ser_ctrl,
    output logic            ser_data,
    output logic            busy,
    output logic            frame_done,
    output logic            len_err
);

    localparam int CNTW = $clog2(OPW + 1);

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [CNTW-1:0] len_eff;
    logic [LENW-1:0] len_field;
    logic            accept, clamp;
    logic            len_bit, mpl_bit, mcd_bit;
    logic            shift_len, shift_mpl, shift_mcd;
    logic            ser_data_nxt, frame_done_nxt;
`ifdef SERIAL_PARITY_EN
    logic            par_acc;
`endif

    assign accept    = in_valid & in_ready;
    assign clamp     = in_length > LENW'(OPW);
    assign len_field = clamp ? LENW'(OPW) : in_length;

    piso_shreg #(.W(LENW)) u_len_sr (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_len),
        .din(len_field), .lsb(len_bit)
    );

    piso_shreg #(.W(OPW)) u_mpl_sr (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_mpl),
        .din(in_mplier), .lsb(mpl_bit)
    );

    piso_shreg #(.W(OPW)) u_mcd_sr (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_mcd),
        .din(in_mcand), .lsb(mcd_bit)
    );

    // cnt holds the cycles remaining in the current field minus one;
    // a field ends on its terminal count of zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                state_nxt = ST_LEN;
                cnt_nxt   = CNTW'(LENW - 1);
            end
            ST_LEN: begin
                if (cnt == '0) begin
                    if (len_eff == '0) begin
                        state_nxt = ST_MCD;
                        cnt_nxt   = CNTW'(OPW - 1);
                    end else begin
                        state_nxt = ST_MPL;
                        cnt_nxt   = len_eff - CNTW'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
            ST_MPL: begin
                if (cnt == '0) begin
                    state_nxt = ST_MCD;
                    cnt_nxt   = CNTW'(OPW - 1);
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
            ST_MCD: begin
                if (cnt == '0) begin
`ifdef SERIAL_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    if (GAP == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = CNTW'(GAP - 1);
                    end
`endif
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PAR: begin
                if (GAP == 0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = CNTW'(GAP - 1);
                end
            end
`endif
            ST_GAP: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - CNTW'(1);
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe; each shift register advances as its
    // current LSB is moved into ser_data.
    always_comb begin
        shift_len    = (state_nxt == ST_LEN);
        shift_mpl    = (state_nxt == ST_MPL);
        shift_mcd    = (state_nxt == ST_MCD);
        ser_data_nxt = 1'b0;
        case (state_nxt)
            ST_LEN:  ser_data_nxt = len_bit;
            ST_MPL:  ser_data_nxt = mpl_bit;
            ST_MCD:  ser_data_nxt = mcd_bit;
`ifdef SERIAL_PARITY_EN
            ST_PAR:  ser_data_nxt = par_acc;
`endif
            default: ser_data_nxt = 1'b0;
        endcase
`ifdef SERIAL_PARITY_EN
        frame_done_nxt = (state_nxt == ST_PAR);
`else
        frame_done_nxt = (state_nxt == ST_MCD) && (cnt_nxt == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            len_eff    <= '0;
            len_err    <= 1'b0;
            in_ready   <= 1'b1;
            ser_ctrl   <= 1'b0;
            ser_data   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            in_ready   <= (state_nxt == ST_IDLE);
            ser_ctrl   <= (state_nxt == ST_START);
            ser_data   <= ser_data_nxt;
            busy       <= (state_nxt != ST_IDLE);
            frame_done <= frame_done_nxt;
            if (accept) begin
                len_eff <= clamp ? CNTW'(OPW) : CNTW'(in_length);
                if (clamp) len_err <= 1'b1;
            end
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_acc <= 1'b0;
        end else if (accept) begin
            par_acc <= 1'b0;
        end else if (shift_len | shift_mpl | shift_mcd) begin
            par_acc <= par_acc ^ ser_data_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed bench for serial_operand_tx (OPW=32, LENW=8, GAP=2).
// Captured vectors use bit i for the cycle i after the accept edge,
// where cycle 0 is the start cycle.
module tb_serial_operand_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_length;
    logic [31:0] in_mplier;
    logic [31:0] in_mcand;
    logic        ser_ctrl;
    logic        ser_data;
    logic        busy;
    logic        frame_done;
    logic        len_err;

    int total = 0;
    int bad   = 0;

    logic [79:0] c_ctrl, c_data, c_done, c_busy, c_rdy;

    serial_operand_tx dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_length(in_length), .in_mplier(in_mplier), .in_mcand(in_mcand),
        .ser_ctrl(ser_ctrl), .ser_data(ser_data), .busy(busy),
        .frame_done(frame_done), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one operand set while idle, then record 80 cycles.
    task automatic send_capture(input logic [7:0] len, input logic [31:0] mpl,
                                input logic [31:0] mcd);
        in_length = len;
        in_mplier = mpl;
        in_mcand  = mcd;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            c_ctrl[i] = ser_ctrl;
            c_data[i] = ser_data;
            c_done[i] = frame_done;
            c_busy[i] = busy;
            c_rdy[i]  = in_ready;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid = 1'b0; in_length = '0; in_mplier = '0; in_mcand = '0;
        #12;
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (ser_ctrl !== 1'b0)   begin bad++; $display("FAIL rst_ser_ctrl got=%b exp=0", ser_ctrl); end
        total++; if (ser_data !== 1'b0)   begin bad++; $display("FAIL rst_ser_data got=%b exp=0", ser_data); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        total++; if (len_err !== 1'b0)    begin bad++; $display("FAIL rst_len_err got=%b exp=0", len_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // len=8, mplier=0xA5, mcand=0x3
    task automatic test_basic_frame;
        send_capture(8'd8, 32'h0000_00A5, 32'h0000_0003);
        total++; if (c_ctrl !== 80'h1) begin bad++; $display("FAIL basic_ctrl got=%h exp=%h", c_ctrl, 80'h1); end
        total++; if (c_data !== 80'h74A10) begin bad++; $display("FAIL basic_data got=%h exp=%h", c_data, 80'h74A10); end
        total++; if (c_done !== (80'd1 << 48)) begin bad++; $display("FAIL basic_done got=%h exp=%h", c_done, 80'd1 << 48); end
        total++; if (c_busy !== ((80'd1 << 51) - 80'd1)) begin bad++; $display("FAIL basic_busy got=%h exp=%h", c_busy, (80'd1 << 51) - 80'd1); end
        total++; if (c_rdy !== ~((80'd1 << 51) - 80'd1)) begin bad++; $display("FAIL basic_ready got=%h exp=%h", c_rdy, ~((80'd1 << 51) - 80'd1)); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL basic_len_err got=%b exp=0", len_err); end
    endtask

    // len=40 clamps to 32: length field 32 (cycle 6), mplier bits 0 and 31
    // at cycles 9 and 40, mcand bit 0 at cycle 41.
    task automatic test_len_clamp;
        logic [79:0] exp_d;
        exp_d = (80'd1 << 6) | (80'd1 << 9) | (80'd1 << 40) | (80'd1 << 41);
        send_capture(8'd40, 32'h8000_0001, 32'h0000_0001);
        total++; if (c_data !== exp_d) begin bad++; $display("FAIL clamp_data got=%h exp=%h", c_data, exp_d); end
        total++; if (c_done !== (80'd1 << 72)) begin bad++; $display("FAIL clamp_done got=%h exp=%h", c_done, 80'd1 << 72); end
        total++; if (c_busy !== ((80'd1 << 75) - 80'd1)) begin bad++; $display("FAIL clamp_busy got=%h exp=%h", c_busy, (80'd1 << 75) - 80'd1); end
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL clamp_len_err got=%b exp=1", len_err); end
    endtask

    // len=0: multiplier skipped, 32 ones on cycles 9..40.
    task automatic test_len_zero;
        logic [79:0] exp_d;
        exp_d = ((80'd1 << 32) - 80'd1) << 9;
        send_capture(8'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        total++; if (c_data !== exp_d) begin bad++; $display("FAIL zero_data got=%h exp=%h", c_data, exp_d); end
        total++; if (c_done !== (80'd1 << 40)) begin bad++; $display("FAIL zero_done got=%h exp=%h", c_done, 80'd1 << 40); end
        total++; if (c_busy !== ((80'd1 << 43) - 80'd1)) begin bad++; $display("FAIL zero_busy got=%h exp=%h", c_busy, (80'd1 << 43) - 80'd1); end
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL zero_len_err_sticky got=%b exp=1", len_err); end
    endtask

    // in_valid held high across two sets: second start on cycle 52.
    task automatic test_back_to_back;
        logic [127:0] rdy_v, ctl_v;
        logic [79:0]  exp_d;
        int second;
        rdy_v = '0; ctl_v = '0; second = -1;
        in_length = 8'd8; in_mplier = 32'hA5; in_mcand = 32'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_length = 8'd3; in_mplier = 32'h5; in_mcand = 32'h2;
        for (int i = 0; i < 120 && second < 0; i++) begin
            rdy_v[i] = in_ready;
            ctl_v[i] = ser_ctrl;
            if (i > 0 && ser_ctrl === 1'b1) begin
                second = i;
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        total++; if (second != 52) begin bad++; $display("FAIL b2b_second_start got=%0d exp=52", second); end
        total++; if (ctl_v[52:0] !== ((53'd1 << 52) | 53'd1)) begin bad++; $display("FAIL b2b_ctrl got=%h exp=%h", ctl_v[52:0], (53'd1 << 52) | 53'd1); end
        total++; if (rdy_v[51:0] !== (52'd1 << 51)) begin bad++; $display("FAIL b2b_ready got=%h exp=%h", rdy_v[51:0], 52'd1 << 51); end
        for (int j = 0; j < 80; j++) begin
            c_data[j] = ser_data;
            c_done[j] = frame_done;
            @(posedge clk); #1;
        end
        exp_d = (80'd1 << 1) | (80'd1 << 2) | (80'd1 << 9) | (80'd1 << 11) | (80'd1 << 13);
        total++; if (c_data !== exp_d) begin bad++; $display("FAIL b2b_second_data got=%h exp=%h", c_data, exp_d); end
        total++; if (c_done !== (80'd1 << 43)) begin bad++; $display("FAIL b2b_second_done got=%h exp=%h", c_done, 80'd1 << 43); end
    endtask

    // Reset asserted during the multiplier field of an all-ones multiplier.
    task automatic test_reset_mid_frame;
        int stray;
        stray = 0;
        in_length = 8'd8; in_mplier = 32'hFF; in_mcand = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; end
        total++; if (ser_data !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midrst_pre got data=%b busy=%b exp 1 1", ser_data, busy); end
        #2 rst = 1'b0;
        #1;
        total++; if (ser_data !== 1'b0 || ser_ctrl !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_async got data=%b ctrl=%b busy=%b exp 0 0 0", ser_data, ser_ctrl, busy); end
        total++; if (in_ready !== 1'b1 || len_err !== 1'b0) begin bad++; $display("FAIL midrst_ready_err got ready=%b len_err=%b exp 1 0", in_ready, len_err); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ser_data !== 1'b0 || ser_ctrl !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) stray++;
            @(posedge clk); #1;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL midrst_no_resume got=%0d bad cycles exp=0", stray); end
        send_capture(8'd8, 32'h0000_00A5, 32'h0000_0003);
        total++; if (c_ctrl !== 80'h1) begin bad++; $display("FAIL midrst_restart_ctrl got=%h exp=%h", c_ctrl, 80'h1); end
        total++; if (c_data !== 80'h74A10) begin bad++; $display("FAIL midrst_restart_data got=%h exp=%h", c_data, 80'h74A10); end
    endtask

`ifdef SERIAL_PARITY_EN
    // Parity cycle at 42 (1+8+1+32); frame_done moves there.
    task automatic test_parity;
        send_capture(8'd1, 32'h1, 32'h0);
        total++; if (c_data !== ((80'd1 << 1) | (80'd1 << 9))) begin bad++; $display("FAIL par_even_data got=%h exp=%h", c_data, (80'd1 << 1) | (80'd1 << 9)); end
        total++; if (c_done !== (80'd1 << 42)) begin bad++; $display("FAIL par_done got=%h exp=%h", c_done, 80'd1 << 42); end
        total++; if (c_busy !== ((80'd1 << 45) - 80'd1)) begin bad++; $display("FAIL par_busy got=%h exp=%h", c_busy, (80'd1 << 45) - 80'd1); end
        send_capture(8'd1, 32'h0, 32'h0);
        total++; if (c_data !== ((80'd1 << 1) | (80'd1 << 42))) begin bad++; $display("FAIL par_odd_data got=%h exp=%h", c_data, (80'd1 << 1) | (80'd1 << 42)); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_len_clamp();
        test_len_zero();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SERIAL_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
